pc_gen: RTL and testbench



---
 rtl/pc_gen_if.sv | 29 ++
 rtl/pc_gen.sv | 151 +++++++++++++++
 tb/tb_pc_gen.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// ============================================================================
// pc_gen_if : fetch-side port bundle of the hxd32 program-counter generator
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic            inc_sel;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            flush;
  logic            misalign;

  modport master (
    output fetch_valid, pc, pc_next, flush, misalign,
    input  fetch_ready, inc_sel
  );

  modport slave (
    input  fetch_valid, pc, pc_next, flush, misalign,
    output fetch_ready, inc_sel
  );
endinterface

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// pc_gen   : handshaked fetch-address source (increment, redirect, trap, mret)
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter bit              C_EXT     = 1'b1
) (
  input  wire logic            clk_i,
  input  wire logic            rst_i,
  pc_gen_if.master             fetch,
  input  wire logic            redir_valid_i,
  input  wire logic            redir_jalr_i,
  input  wire logic [XLEN-1:0] redir_target_i,
  input  wire logic            trap_i,
  input  wire logic            trap_irq_i,
  input  wire logic [4:0]      trap_cause_i,
  input  wire logic [XLEN-1:0] mtvec_i,
  input  wire logic            mret_i,
  input  wire logic [XLEN-1:0] mepc_i
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] c_inc2 = XLEN'(2);
  localparam logic [XLEN-1:0] c_inc4 = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            valid_q, valid_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;

  logic            ev_valid;
  logic [XLEN-1:0] ev_target;
  logic            redir_bad;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] trap_tgt;
  logic [XLEN-1:0] mret_tgt;
  logic [XLEN-1:0] pc_inc;

  assign pc_inc = (C_EXT && fetch.inc_sel) ? c_inc2 : c_inc4;

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  always_comb begin
    trap_tgt = {mtvec_i[XLEN-1:2], 2'b00};
    if (mtvec_i[1:0] == 2'b01 && trap_irq_i) begin
      trap_tgt = trap_tgt + {{(XLEN-7){1'b0}}, trap_cause_i, 2'b00};
    end
  end

  always_comb begin
    mret_tgt = C_EXT ? {mepc_i[XLEN-1:1], 1'b0} : {mepc_i[XLEN-1:2], 2'b00};
    redir_tgt = redir_jalr_i ? {redir_target_i[XLEN-1:1], 1'b0} : redir_target_i;
    redir_bad = redir_tgt[0] || (!C_EXT && redir_tgt[1]);
  end

  always_comb begin
    ev_valid  = 1'b0;
    ev_target = '0;
    if (trap_i) begin
      ev_valid  = 1'b1;
      ev_target = trap_tgt;
    end else if (mret_i) begin
      ev_valid  = 1'b1;
      ev_target = mret_tgt;
    end else if (redir_valid_i && !redir_bad) begin
      ev_valid  = 1'b1;
      ev_target = redir_tgt;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    valid_d    = valid_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        valid_d = 1'b1;
      end
      ST_RUN: begin
        misalign_d = !trap_i && !mret_i && redir_valid_i && redir_bad;
        if (ev_valid) begin
          if (fetch.fetch_ready) begin
            pc_d    = ev_target;
            flush_d = 1'b1;
          end else begin
            pend_d  = ev_target;
            state_d = ST_HOLD;
          end
        end else if (fetch.fetch_ready) begin
          pc_d = pc_q + pc_inc;
        end
      end
      ST_HOLD: begin
        misalign_d = !trap_i && !mret_i && redir_valid_i && redir_bad;
        if (fetch.fetch_ready) begin
          pc_d    = ev_valid ? ev_target : pend_q;
          flush_d = 1'b1;
          state_d = ST_RUN;
        end else if (ev_valid) begin
          pend_d = ev_target;
        end
      end
      default: begin
        state_d = ST_BOOT;
        valid_d = 1'b0;
        pc_d    = RESET_VEC;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      pend_q     <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign fetch.fetch_valid = valid_q;
  assign fetch.pc          = pc_q;
  assign fetch.pc_next     = pc_q + pc_inc;
  assign fetch.flush       = flush_q;
  assign fetch.misalign    = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// tb_pc_gen : directed bench for pc_gen, compressed and 4-byte-only variants
// Revision  : 1.0
// ============================================================================
`default_nettype none

module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b1;
  logic        inc_sel = 1'b0;
  logic        redir = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] target = '0;
  logic        trap = 1'b0;
  logic        irq = 1'b0;
  logic [4:0]  cause = '0;
  logic [31:0] mtvec = '0;
  logic        mret = 1'b0;
  logic [31:0] mepc = '0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32)) if_c ();
  pc_gen_if #(.XLEN(32)) if_n ();

  assign if_c.fetch_ready = ready;
  assign if_c.inc_sel     = inc_sel;
  assign if_n.fetch_ready = ready;
  assign if_n.inc_sel     = inc_sel;

  pc_gen #(.XLEN(32), .RESET_VEC(RV), .C_EXT(1'b1)) dut_c (
    .clk_i(clk), .rst_i(rst), .fetch(if_c.master),
    .redir_valid_i(redir), .redir_jalr_i(jalr), .redir_target_i(target),
    .trap_i(trap), .trap_irq_i(irq), .trap_cause_i(cause), .mtvec_i(mtvec),
    .mret_i(mret), .mepc_i(mepc)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(RV), .C_EXT(1'b0)) dut_n (
    .clk_i(clk), .rst_i(rst), .fetch(if_n.master),
    .redir_valid_i(redir), .redir_jalr_i(jalr), .redir_target_i(target),
    .trap_i(trap), .trap_irq_i(irq), .trap_cause_i(cause), .mtvec_i(mtvec),
    .mret_i(mret), .mepc_i(mepc)
  );

  // Reference model: "is fetching", current pc, optional pending target.
  typedef struct packed {
    logic        live;
    logic [31:0] pc;
    logic        has_pend;
    logic [31:0] pend;
    logic        flush;
    logic        mis;
  } mst_t;

  mst_t m_c, m_n;
  bit   m_init = 1'b0;

  function automatic logic [31:0] m_inc(bit cext);
    return (cext && inc_sel) ? 32'd2 : 32'd4;
  endfunction

  function automatic mst_t model_step(mst_t s, bit cext);
    mst_t        n;
    logic        ev;
    logic [31:0] tgt;
    n       = s;
    n.flush = 1'b0;
    n.mis   = 1'b0;
    ev      = 1'b0;
    tgt     = '0;
    if (rst) begin
      n.live = 1'b0; n.pc = RV; n.has_pend = 1'b0; n.pend = '0;
      return n;
    end
    if (!s.live) begin
      n.live = 1'b1;
      return n;
    end
    if (trap) begin
      ev  = 1'b1;
      tgt = mtvec & 32'hFFFF_FFFC;
      if (mtvec % 4 == 1 && irq) tgt = tgt + 32'(cause) * 4;
    end else if (mret) begin
      ev  = 1'b1;
      tgt = cext ? (mepc & 32'hFFFF_FFFE) : (mepc & 32'hFFFF_FFFC);
    end else if (redir) begin
      tgt = jalr ? (target & 32'hFFFF_FFFE) : target;
      if ((cext && tgt % 2 != 0) || (!cext && tgt % 4 != 0)) n.mis = 1'b1;
      else ev = 1'b1;
    end
    if (ready) begin
      if (ev) begin
        n.pc = tgt; n.flush = 1'b1; n.has_pend = 1'b0;
      end else if (s.has_pend) begin
        n.pc = s.pend; n.flush = 1'b1; n.has_pend = 1'b0;
      end else begin
        n.pc = s.pc + m_inc(cext);
      end
    end else if (ev) begin
      n.has_pend = 1'b1; n.pend = tgt;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m_c    <= model_step(m_c, 1'b1);
    m_n    <= model_step(m_n, 1'b0);
    m_init <= 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      chk("c.valid",    32'(if_c.fetch_valid), 32'(m_c.live));
      chk("c.pc",       if_c.pc,               m_c.pc);
      chk("c.pc_next",  if_c.pc_next,          m_c.pc + m_inc(1'b1));
      chk("c.flush",    32'(if_c.flush),       32'(m_c.flush));
      chk("c.misalign", 32'(if_c.misalign),    32'(m_c.mis));
      chk("n.valid",    32'(if_n.fetch_valid), 32'(m_n.live));
      chk("n.pc",       if_n.pc,               m_n.pc);
      chk("n.pc_next",  if_n.pc_next,          m_n.pc + m_inc(1'b0));
      chk("n.flush",    32'(if_n.flush),       32'(m_n.flush));
      chk("n.misalign", 32'(if_n.misalign),    32'(m_n.mis));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    chk("lit reset pc",    if_c.pc, RV);
    chk("lit reset valid", 32'(if_c.fetch_valid), 32'd0);
    chk("lit reset flush", 32'(if_c.flush), 32'd0);
    rst = 1'b0;
    tick();
    chk("lit boot->run valid", 32'(if_c.fetch_valid), 32'd1);
    chk("lit first pc",        if_c.pc, 32'h100);
    tick(); chk("lit seq 104", if_c.pc, 32'h104);
    tick(); chk("lit seq 108", if_c.pc, 32'h108);
    inc_sel = 1'b1; #1;
    chk("lit pc_next +2", if_c.pc_next, 32'h10A);
    tick(); chk("lit seq 10A", if_c.pc, 32'h10A);
    chk("lit n seq 10C", if_n.pc, 32'h10C);
    inc_sel = 1'b0;
    tick(); chk("lit seq 10E", if_c.pc, 32'h10E);

    redir = 1'b1; target = 32'h200;
    tick(); chk("lit redir 200", if_c.pc, 32'h200);
    chk("lit redir flush", 32'(if_c.flush), 32'd1);
    ready = 1'b0; target = 32'h400;
    tick(); chk("lit stall pc 1", if_c.pc, 32'h200);
    redir = 1'b0;
    tick(); chk("lit stall pc 2", if_c.pc, 32'h200);
    tick(); chk("lit stall pc 3", if_c.pc, 32'h200);
    chk("lit stall valid", 32'(if_c.fetch_valid), 32'd1);
    ready = 1'b1;
    tick(); chk("lit pend 400", if_c.pc, 32'h400);
    chk("lit pend flush", 32'(if_c.flush), 32'd1);
    tick(); chk("lit after pend", if_c.pc, 32'h404);
    chk("lit flush drop", 32'(if_c.flush), 32'd0);

    trap = 1'b1; irq = 1'b1; cause = 5'd7; mtvec = 32'h8000_0001;
    redir = 1'b1; target = 32'h1234;
    tick(); chk("lit vectored trap", if_c.pc, 32'h8000_001C);
    redir = 1'b0; irq = 1'b0;
    tick(); chk("lit exception trap", if_c.pc, 32'h8000_0000);
    trap = 1'b0; mret = 1'b1; mepc = 32'h0000_0503;
    tick(); chk("lit mret c", if_c.pc, 32'h502);
    chk("lit mret n", if_n.pc, 32'h500);
    mret = 1'b0;

    redir = 1'b1; target = 32'h302;
    tick(); chk("lit c 302", if_c.pc, 32'h302);
    chk("lit n misalign", 32'(if_n.misalign), 32'd1);
    chk("lit n drop +4", if_n.pc, 32'h504);
    redir = 1'b0;
    tick(); chk("lit n misalign pulse", 32'(if_n.misalign), 32'd0);
    chk("lit n 508", if_n.pc, 32'h508);
    redir = 1'b1; jalr = 1'b1; target = 32'h305;
    tick(); chk("lit jalr 304", if_c.pc, 32'h304);
    jalr = 1'b0; target = 32'h301;
    tick(); chk("lit c misalign", 32'(if_c.misalign), 32'd1);
    chk("lit c drop +4", if_c.pc, 32'h308);

    target = 32'hFFFF_FFFC;
    tick(); chk("lit top", if_c.pc, 32'hFFFF_FFFC);
    redir = 1'b0;
    tick(); chk("lit wrap", if_c.pc, 32'h0);
    chk("lit wrap noflush", 32'(if_c.flush), 32'd0);

    ready = 1'b0; redir = 1'b1; target = 32'h600;
    tick(); target = 32'h700;
    tick(); chk("lit hold pc", if_c.pc, 32'h0);
    redir = 1'b0; ready = 1'b1;
    tick(); chk("lit newest wins", if_c.pc, 32'h700);
    ready = 1'b0; redir = 1'b1; target = 32'h600;
    tick(); ready = 1'b1; target = 32'h800;
    tick(); chk("lit same-cycle override", if_c.pc, 32'h800);

    ready = 1'b0; target = 32'h400;
    tick(); redir = 1'b0;
    tick(); chk("lit hold before rst", if_c.pc, 32'h800);
    rst = 1'b1;
    tick(); chk("lit rst pc", if_c.pc, RV);
    chk("lit rst valid", 32'(if_c.fetch_valid), 32'd0);
    rst = 1'b0; ready = 1'b1;
    tick(); chk("lit post-rst pc", if_c.pc, RV);
    tick(); chk("lit no stale pend", if_c.pc, 32'h104);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
